snake_grid_writer: RTL and testbench

Double-buffered writer for the 64x48 two-bit-per-cell game grid that the VGA output stage scans. Game logic issues single-cell writes, whole-grid clears and cell reads against a back buffer. On request, the back buffer is published to the front buffer only at a vertical-blank pulse, so the display never shows a half-updated frame. `grid_flat` feeds the VGA interface directly.

---
 rtl/snake_grid_pkg.sv | 29 ++
 rtl/snake_grid_writer.sv | 125 ++++++++++++
 tb/tb_snake_grid_writer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/snake_grid_pkg.sv
// Shared grid geometry, color encoding and cell addressing for the snake game grid.
package snake_grid_pkg;

    localparam int unsigned GRID_W     = 64;
    localparam int unsigned GRID_H     = 48;
    localparam int unsigned CELL_BITS  = 2;
    localparam int unsigned COORD_W    = 6;
    localparam int unsigned GRID_CELLS = GRID_W * GRID_H;
    localparam int unsigned IDX_W      = $clog2(GRID_CELLS);

    typedef logic [CELL_BITS-1:0] color_t;

    localparam color_t COLOR_BLACK = 2'b00;
    localparam color_t COLOR_RED   = 2'b01;
    localparam color_t COLOR_GREEN = 2'b10;
    localparam color_t COLOR_BLUE  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } grid_state_e;

    // Linear cell index; the bit offset in a flat grid is cell_index * CELL_BITS.
    function automatic logic [IDX_W-1:0] cell_index(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return IDX_W'(32'(y) * GRID_W + 32'(x));
    endfunction

endpackage

// File: rtl/snake_grid_writer.sv
// Double-buffered game-grid writer: edits land in the back buffer, which is
// copied to the displayed front buffer only on a vertical-blank pulse.
module snake_grid_writer #(
    parameter int unsigned GRID_W    = snake_grid_pkg::GRID_W,
    parameter int unsigned GRID_H    = snake_grid_pkg::GRID_H,
    parameter int unsigned CELL_BITS = snake_grid_pkg::CELL_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [5:0]                          wr_x,
    input  logic [5:0]                          wr_y,
    input  logic [CELL_BITS-1:0]                wr_color,
    output logic                                wr_err,
    input  logic                                clr_req,
    input  logic [CELL_BITS-1:0]                clr_color,
    output logic                                busy,
    input  logic [5:0]                          rd_x,
    input  logic [5:0]                          rd_y,
    output logic [CELL_BITS-1:0]                rd_color,
    input  logic                                commit_req,
    input  logic                                vblank_pulse,
    output logic                                commit_done,
    output logic [GRID_W*GRID_H*CELL_BITS-1:0]  grid_flat
);
    import snake_grid_pkg::*;

    localparam int unsigned ROW_BITS  = GRID_W * CELL_BITS;
    localparam int unsigned GRID_BITS = ROW_BITS * GRID_H;
    localparam int unsigned OFF_W     = $clog2(GRID_BITS);
    localparam int unsigned ROW_W     = $clog2(GRID_H);

    grid_state_e            state, state_next;
    logic [ROW_W-1:0]       row, row_next;
    logic [CELL_BITS-1:0]   fill_color;
    logic [GRID_BITS-1:0]   back;
    logic                   pending;

    int unsigned            wx, wy, rx, ry;
    logic                   wr_in_range, rd_in_range;
    logic                   wr_take, wr_fire, publish;
    logic [OFF_W-1:0]       wr_off, rd_off, row_off;

    // Coordinate range checks and bit offsets into the flat back buffer.
    always_comb begin
        wx          = 32'(wr_x);
        wy          = 32'(wr_y);
        rx          = 32'(rd_x);
        ry          = 32'(rd_y);
        wr_in_range = (wx < GRID_W) && (wy < GRID_H);
        rd_in_range = (rx < GRID_W) && (ry < GRID_H);
        wr_off      = wr_in_range ? OFF_W'((wy * GRID_W + wx) * CELL_BITS) : '0;
        rd_off      = rd_in_range ? OFF_W'((ry * GRID_W + rx) * CELL_BITS) : '0;
        row_off     = OFF_W'(32'(row) * ROW_BITS);
    end

    assign wr_take = wr_valid && wr_ready;
    assign wr_fire = wr_take && wr_in_range;
    assign publish = vblank_pulse && (pending || commit_req) && (state == ST_IDLE);

    // FSM state and clear-row counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            row   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
        end
    end

    // Next-state logic: a clear sweeps one row per cycle then returns to idle.
    always_comb begin
        state_next = state;
        row_next   = row;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    row_next   = '0;
                end
            end
            ST_CLEAR: begin
                row_next = row + ROW_W'(1);
                if (32'(row) == GRID_H - 1) begin
                    state_next = ST_IDLE;
                    row_next   = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Buffers, commit tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            back        <= '0;
            grid_flat   <= '0;
            fill_color  <= '0;
            pending     <= 1'b0;
            rd_color    <= COLOR_BLACK;
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
            busy        <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            if (wr_fire)
                back[wr_off +: CELL_BITS] <= wr_color;
            if (state == ST_CLEAR)
                back[row_off +: ROW_BITS] <= {GRID_W{fill_color}};
            if ((state == ST_IDLE) && clr_req)
                fill_color <= clr_color;
            rd_color    <= rd_in_range ? back[rd_off +: CELL_BITS] : COLOR_BLACK;
            wr_err      <= wr_take && !wr_in_range;
            if (publish)
                grid_flat <= back;
            pending     <= publish ? 1'b0 : (pending || commit_req);
            commit_done <= publish;
            busy        <= (state_next == ST_CLEAR);
            wr_ready    <= (state_next == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_snake_grid_writer.sv
// Scoreboard bench for snake_grid_writer: a cell-array reference model predicts
// every cycle's outputs, a monitor compares them after each clock edge.
module tb_snake_grid_writer;
    import snake_grid_pkg::*;

    localparam int unsigned NB = GRID_W * GRID_H * CELL_BITS;

    logic          clk = 1'b0;
    logic          reset, wr_valid, wr_ready, wr_err, clr_req, busy;
    logic          commit_req, vblank_pulse, commit_done;
    logic [5:0]    wr_x, wr_y, rd_x, rd_y;
    logic [1:0]    wr_color, clr_color, rd_color;
    logic [NB-1:0] grid_flat;

    always #10 clk = ~clk;

    snake_grid_writer dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_err(wr_err),
        .clr_req(clr_req), .clr_color(clr_color), .busy(busy),
        .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
        .commit_req(commit_req), .vblank_pulse(vblank_pulse),
        .commit_done(commit_done), .grid_flat(grid_flat)
    );

    typedef struct {
        logic [1:0]    rd;
        logic          err;
        logic          done;
        logic          bsy;
        logic          rdy;
        logic [NB-1:0] grid;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: cell arrays plus a count of remaining clear rows.
    logic [1:0]    back_m [GRID_H][GRID_W];
    logic [NB-1:0] front_m = '0;
    int            clr_left = 0;
    int            clr_row  = 0;
    logic [1:0]    clr_col  = 2'b00;
    logic          pend_m   = 1'b0;

    function automatic logic [NB-1:0] snapshot();
        logic [NB-1:0] s;
        s = '0;
        for (int y = 0; y < GRID_H; y++)
            for (int x = 0; x < GRID_W; x++)
                s[2*(y*GRID_W+x) +: 2] = back_m[y][x];
        return s;
    endfunction

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        exp_t e;
        logic idle, pub;
        if (reset) begin
            for (int y = 0; y < GRID_H; y++)
                for (int x = 0; x < GRID_W; x++)
                    back_m[y][x] = 2'b00;
            front_m  = '0;
            clr_left = 0;
            clr_row  = 0;
            pend_m   = 1'b0;
            e.rd = 2'b00; e.err = 1'b0; e.done = 1'b0; e.bsy = 1'b0; e.rdy = 1'b1;
        end else begin
            idle = (clr_left == 0);
            e.rd = (int'(rd_y) < GRID_H && int'(rd_x) < GRID_W) ? back_m[rd_y][rd_x] : 2'b00;
            pub  = vblank_pulse && (pend_m || commit_req) && idle;
            if (pub) front_m = snapshot();
            pend_m = pub ? 1'b0 : (pend_m || commit_req);
            e.err  = idle && wr_valid && !(int'(wr_y) < GRID_H && int'(wr_x) < GRID_W);
            if (idle && wr_valid && int'(wr_y) < GRID_H && int'(wr_x) < GRID_W)
                back_m[wr_y][wr_x] = wr_color;
            if (!idle) begin
                for (int x = 0; x < GRID_W; x++) back_m[clr_row][x] = clr_col;
                clr_row++;
                clr_left--;
            end else if (clr_req) begin
                clr_left = GRID_H;
                clr_row  = 0;
                clr_col  = clr_color;
            end
            e.done = pub;
            e.bsy  = (clr_left != 0);
            e.rdy  = (clr_left == 0);
        end
        e.grid = front_m;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 1'b0; wr_valid = 1'b0; clr_req = 1'b0; commit_req = 1'b0; vblank_pulse = 1'b0;
    endtask

    task automatic write(input int x, input int y, input int c);
        wr_valid = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_color = 2'(c);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: after each edge pop the prediction and compare every output.
    initial begin
        exp_t          e;
        logic [NB-1:0] g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_color", 32'(rd_color), 32'(e.rd));
                chk("wr_err", 32'(wr_err), 32'(e.err));
                chk("commit_done", 32'(commit_done), 32'(e.done));
                chk("busy", 32'(busy), 32'(e.bsy));
                chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
                g = grid_flat;
                total++;
                if (g !== e.grid) begin
                    bad++;
                    for (int i = 0; i < GRID_W * GRID_H; i++) begin
                        if (g[2*i +: 2] !== e.grid[2*i +: 2]) begin
                            $display("FAIL grid_flat cell=%0d got=%0h exp=%0h t=%0t",
                                     i, g[2*i +: 2], e.grid[2*i +: 2], $time);
                            break;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        quiet();
        reset = 1'b1;
        wr_x = '0; wr_y = '0; wr_color = '0; clr_color = '0; rd_x = '0; rd_y = '0;
        tick(); tick();
        quiet(); tick();

        // Single write then read back; front buffer stays zero.
        write(5, 3, 2); tick();
        quiet(); rd_x = 6'd5; rd_y = 6'd3; tick();
        tick();

        // Corner write, commit, publish 20 cycles later.
        write(63, 47, 3); tick();
        quiet(); commit_req = 1'b1; tick();
        quiet(); repeat (19) tick();
        vblank_pulse = 1'b1; tick();
        quiet(); tick(); tick();

        // Out-of-range rows are accepted but dropped.
        write(0, 48, 1); tick();
        write(10, 63, 3); tick();
        quiet(); rd_x = 6'd0; rd_y = 6'd48; tick();
        tick();

        // Clear with a skipped vblank mid-sweep, then publish.
        clr_req = 1'b1; clr_color = 2'b10; commit_req = 1'b1; tick();
        quiet(); repeat (10) tick();
        vblank_pulse = 1'b1; write(1, 1, 1); tick();
        quiet(); clr_req = 1'b1; clr_color = 2'b01; tick();
        quiet(); repeat (40) tick();
        for (int i = 0; i < 8; i++) begin
            rd_x = 6'($urandom_range(0, 63)); rd_y = 6'($urandom_range(0, 47)); tick();
        end
        vblank_pulse = 1'b1; tick();
        quiet(); tick();

        // Coalesced commits, then write racing a publish.
        commit_req = 1'b1; tick();
        quiet(); tick();
        commit_req = 1'b1; tick();
        quiet(); vblank_pulse = 1'b1; tick();
        quiet(); tick(); tick();
        commit_req = 1'b1; tick();
        quiet(); vblank_pulse = 1'b1; write(7, 7, 3); tick();
        quiet(); commit_req = 1'b1; tick();
        quiet(); vblank_pulse = 1'b1; tick();
        quiet(); tick();

        // Write and clear on the same edge: clear overwrites the write.
        write(2, 0, 1); clr_req = 1'b1; clr_color = 2'b11; tick();
        quiet(); repeat (50) tick();

        // Reset partway through a clear with a commit pending.
        write(3, 3, 2); tick();
        quiet(); commit_req = 1'b1; clr_req = 1'b1; clr_color = 2'b01; tick();
        quiet(); repeat (19) tick();
        reset = 1'b1; tick();
        quiet(); rd_x = 6'd3; rd_y = 6'd3; tick();
        vblank_pulse = 1'b1; tick();
        quiet(); tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 299) == 0);
            wr_valid     = 1'($urandom_range(0, 1));
            wr_x         = 6'($urandom_range(0, 63));
            wr_y         = 6'($urandom_range(0, 55));
            wr_color     = 2'($urandom_range(0, 3));
            clr_req      = ($urandom_range(0, 99) == 0);
            clr_color    = 2'($urandom_range(0, 3));
            commit_req   = ($urandom_range(0, 19) == 0);
            vblank_pulse = ($urandom_range(0, 29) == 0);
            rd_x         = 6'($urandom_range(0, 63));
            rd_y         = 6'($urandom_range(0, 51));
            tick();
        end
        quiet(); tick(); tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
